// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types and constants for the pipeline hazard controller.
//   state_e : FSM encoding (RUN / MDU_WAIT)
//   ctrl_t  : bundle of the six front-end control outputs
//   CTRL_*  : canned control vectors used by the FSM
package hazard_pkg;

    typedef enum logic {
        RUN      = 1'b0,
        MDU_WAIT = 1'b1
    } state_e;

    typedef struct packed {
        logic pc_write;
        logic if_id_write;
        logic if_id_flush;
        logic id_ex_flush;
        logic id_ex_hold;
        logic ex_mem_bubble;
    } ctrl_t;

    // Normal forward progress: PC and IF/ID load, nothing flushed or held.
    localparam ctrl_t CTRL_ADVANCE = '{pc_write: 1'b1, if_id_write: 1'b1, default: 1'b0};

    // Taken branch: keep fetching the redirect target, squash IF/ID and ID/EX.
    localparam ctrl_t CTRL_BRANCH  = '{pc_write: 1'b1, if_id_write: 1'b1,
                                      if_id_flush: 1'b1, id_ex_flush: 1'b1,
                                      default: 1'b0};

    // MDU busy: freeze the front end and the op in EX, feed bubbles to MEM.
    localparam ctrl_t CTRL_MDU     = '{id_ex_hold: 1'b1, ex_mem_bubble: 1'b1, default: 1'b0};

    // Load-use: freeze PC and IF/ID, insert one bubble into ID/EX.
    localparam ctrl_t CTRL_LOADUSE = '{id_ex_flush: 1'b1, default: 1'b0};

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// sat_counter: W-bit event counter that saturates at all-ones.
//   clk   : clock, rising edge
//   reset : asynchronous active-high reset, clears count
//   inc   : count one event this cycle
//   count : current value, holds at all-ones once reached
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {W{1'b1}}))
            count_d = count_q + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) count_q <= '0;
        else       count_q <= count_d;
    end

    assign count = count_q;

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: front-end stall/flush controller for the 5-stage core.
// Resolves load-use hazards, taken-branch flushes and multi-cycle MDU ops.
//   clk, reset                    : clock, async active-high reset
//   id_rs1/rs2, id_use_rs1/rs2    : ID source registers and read enables
//   id_ex_rd, id_ex_memread       : EX destination, EX instruction is a load
//   ex_branch_taken               : EX redirects the PC
//   mdu_start, mdu_done           : MDU op in EX / MDU result valid
//   pc_write .. ex_mem_bubble     : combinational pipeline register controls
//   mdu_timeout                   : sticky watchdog error, cleared by reset
//   stall_cnt, flush_cnt          : saturating performance counters
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int CNT_W       = 32,
    parameter int MDU_MAX_CYC = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [4:0]       id_ex_rd,
    input  logic             id_ex_memread,
    input  logic             ex_branch_taken,
    input  logic             mdu_start,
    input  logic             mdu_done,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             id_ex_hold,
    output logic             ex_mem_bubble,
    output logic             mdu_timeout,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int              WD_W    = (MDU_MAX_CYC > 1) ? $clog2(MDU_MAX_CYC) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(MDU_MAX_CYC - 1);

    state_e          state_q, state_d;
    logic [WD_W-1:0] wd_q, wd_d;
    logic            timeout_q, timeout_set;
    logic            flush_ev;
    logic            load_use;
    ctrl_t           ctrl;

    // x0 is never a real dependency, so a load to x0 cannot cause a stall.
    assign load_use = id_ex_memread && (id_ex_rd != 5'd0) &&
                      ((id_use_rs1 && (id_rs1 == id_ex_rd)) ||
                       (id_use_rs2 && (id_rs2 == id_ex_rd)));

    always_comb begin
        ctrl        = CTRL_ADVANCE;
        state_d     = state_q;
        wd_d        = wd_q;
        timeout_set = 1'b0;
        flush_ev    = 1'b0;
        // While reset is held the registers are already in RUN; forcing the
        // advance vector keeps stale MDU inputs from showing a stall.
        if (!reset) begin
            unique case (state_q)
                RUN: begin
                    if (ex_branch_taken) begin
                        ctrl     = CTRL_BRANCH;
                        flush_ev = 1'b1;
                    end else if (mdu_start && !mdu_done) begin
                        ctrl    = CTRL_MDU;
                        state_d = MDU_WAIT;
                        wd_d    = '0;
                    end else if (mdu_start) begin
                        ctrl = CTRL_ADVANCE;   // single-cycle MDU result
                    end else if (load_use) begin
                        ctrl = CTRL_LOADUSE;
                    end
                end
                MDU_WAIT: begin
                    if (mdu_done) begin
                        state_d = RUN;
                    end else if (wd_q == WD_LAST) begin
                        // Entry cycle plus MDU_MAX_CYC-1 wait cycles have
                        // stalled; give up and let the pipe move on.
                        timeout_set = 1'b1;
                        state_d     = RUN;
                    end else begin
                        ctrl = CTRL_MDU;
                        wd_d = wd_q + 1'b1;
                    end
                end
                default: state_d = RUN;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= RUN;
            wd_q      <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wd_q      <= wd_d;
            if (timeout_set) timeout_q <= 1'b1;
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (!ctrl.pc_write),
        .count (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (flush_ev),
        .count (flush_cnt)
    );

    assign pc_write      = ctrl.pc_write;
    assign if_id_write   = ctrl.if_id_write;
    assign if_id_flush   = ctrl.if_id_flush;
    assign id_ex_flush   = ctrl.id_ex_flush;
    assign id_ex_hold    = ctrl.id_ex_hold;
    assign ex_mem_bubble = ctrl.ex_mem_bubble;
    assign mdu_timeout   = timeout_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl (CNT_W=4, MDU_MAX_CYC=8).
// Expected control vectors are {pc_write, if_id_write, if_id_flush,
// id_ex_flush, id_ex_hold, ex_mem_bubble}.
module tb_hazard_ctrl;

    localparam int CNT_W = 4;
    localparam int MAXC  = 8;

    localparam logic [5:0] ADV = 6'b110000;
    localparam logic [5:0] BR  = 6'b111100;
    localparam logic [5:0] MDU = 6'b000011;
    localparam logic [5:0] LU  = 6'b000100;

    logic             clk = 1'b0;
    logic             reset;
    logic [4:0]       id_rs1, id_rs2, id_ex_rd;
    logic             id_use_rs1, id_use_rs2, id_ex_memread;
    logic             ex_branch_taken, mdu_start, mdu_done;
    logic             pc_write, if_id_write, if_id_flush, id_ex_flush;
    logic             id_ex_hold, ex_mem_bubble, mdu_timeout;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    hazard_ctrl #(.CNT_W(CNT_W), .MDU_MAX_CYC(MAXC)) dut (
        .clk(clk), .reset(reset),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_ex_rd(id_ex_rd), .id_ex_memread(id_ex_memread),
        .ex_branch_taken(ex_branch_taken),
        .mdu_start(mdu_start), .mdu_done(mdu_done),
        .pc_write(pc_write), .if_id_write(if_id_write),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
        .id_ex_hold(id_ex_hold), .ex_mem_bubble(ex_mem_bubble),
        .mdu_timeout(mdu_timeout),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic       mr;
        logic [4:0] rd, rs1, rs2;
        logic       u1, u2, br, ms, md;
        logic [5:0] exp;
    } vec_t;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int exp_stall = 0;
    int exp_flush = 0;
    logic exp_to  = 1'b0;

    function automatic vec_t mkv(string n, logic mr, logic [4:0] rd, logic [4:0] rs1,
                                 logic [4:0] rs2, logic u1, logic u2, logic br,
                                 logic ms, logic md, logic [5:0] exp);
        vec_t v;
        v.name = n; v.mr = mr; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
        v.u1 = u1; v.u2 = u2; v.br = br; v.ms = ms; v.md = md; v.exp = exp;
        return v;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [5:0] outs();
        return {pc_write, if_id_write, if_id_flush, id_ex_flush, id_ex_hold, ex_mem_bubble};
    endfunction

    task automatic drive(vec_t v);
        id_ex_memread = v.mr; id_ex_rd = v.rd; id_rs1 = v.rs1; id_rs2 = v.rs2;
        id_use_rs1 = v.u1; id_use_rs2 = v.u2; ex_branch_taken = v.br;
        mdu_start = v.ms; mdu_done = v.md;
    endtask

    // One full cycle: apply, check combinational outputs mid-cycle, clock,
    // then check the registered counters against the bench model.
    task automatic step(vec_t v, logic set_to);
        drive(v);
        #4;
        check({v.name, " ctrl"}, 32'(outs()), 32'(v.exp));
        @(posedge clk); #1;
        if (!v.exp[5] && exp_stall < 15) exp_stall++;
        if (v.exp[3]  && exp_flush < 15) exp_flush++;
        if (set_to) exp_to = 1'b1;
        check({v.name, " stall_cnt"}, 32'(stall_cnt), 32'(exp_stall));
        check({v.name, " flush_cnt"}, 32'(flush_cnt), 32'(exp_flush));
        check({v.name, " timeout"},   32'(mdu_timeout), 32'(exp_to));
    endtask

    vec_t tbl[$];
    vec_t idle;

    initial begin
        idle = mkv("idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, ADV);
        tbl.push_back(mkv("idle",          0, 0, 0, 0, 0, 0, 0, 0, 0, ADV));
        tbl.push_back(mkv("lu_rs1",        1, 5, 5, 0, 1, 0, 0, 0, 0, LU));
        tbl.push_back(mkv("lu_cleared",    0, 5, 5, 0, 1, 0, 0, 0, 0, ADV));
        tbl.push_back(mkv("load_x0",       1, 0, 0, 0, 1, 0, 0, 0, 0, ADV));
        tbl.push_back(mkv("rs2_unused",    1, 5, 0, 5, 0, 0, 0, 0, 0, ADV));
        tbl.push_back(mkv("lu_rs2",        1, 5, 0, 5, 0, 1, 0, 0, 0, LU));
        tbl.push_back(mkv("rd_mismatch",   1, 6, 5, 7, 1, 1, 0, 0, 0, ADV));
        tbl.push_back(mkv("br_over_lu",    1, 5, 5, 0, 1, 0, 1, 0, 0, BR));
        tbl.push_back(mkv("mdu_1cyc",      0, 0, 0, 0, 0, 0, 0, 1, 1, ADV));
        tbl.push_back(mkv("mdu1_over_lu",  1, 5, 5, 0, 1, 0, 0, 1, 1, ADV));
        tbl.push_back(mkv("br_over_mdu",   0, 0, 0, 0, 0, 0, 1, 1, 0, BR));
        tbl.push_back(mkv("still_run",     0, 0, 0, 0, 0, 0, 0, 0, 0, ADV));

        // Reset state with idle inputs.
        reset = 1'b1;
        drive(idle);
        repeat (2) @(posedge clk);
        #1;
        check("reset ctrl",      32'(outs()), 32'(ADV));
        check("reset stall_cnt", 32'(stall_cnt), 0);
        check("reset flush_cnt", 32'(flush_cnt), 0);
        check("reset timeout",   32'(mdu_timeout), 0);
        reset = 1'b0;

        foreach (tbl[i]) step(tbl[i], 1'b0);

        // MDU op: start at cycle 0, done at cycle 3; branch at cycle 1 ignored.
        step(mkv("mdu_c0", 0, 0, 0, 0, 0, 0, 0, 1, 0, MDU), 1'b0);
        step(mkv("mdu_c1", 1, 5, 5, 0, 1, 0, 1, 1, 0, MDU), 1'b0);
        step(mkv("mdu_c2", 0, 0, 0, 0, 0, 0, 0, 1, 0, MDU), 1'b0);
        step(mkv("mdu_c3", 0, 0, 0, 0, 0, 0, 0, 1, 1, ADV), 1'b0);
        step(idle, 1'b0);

        // Watchdog: done never comes; 8 stalled cycles then forced advance.
        step(mkv("wd_entry", 0, 0, 0, 0, 0, 0, 0, 1, 0, MDU), 1'b0);
        for (int i = 0; i < MAXC - 1; i++)
            step(mkv("wd_wait", 0, 0, 0, 0, 0, 0, 0, 0, 0, MDU), 1'b0);
        step(mkv("wd_expire", 0, 0, 0, 0, 0, 0, 0, 0, 0, ADV), 1'b1);
        step(mkv("wd_run_lu", 1, 5, 5, 0, 1, 0, 0, 0, 0, LU), 1'b0);
        for (int i = 0; i < 3; i++) step(idle, 1'b0);

        // Saturation: more stalls and flushes than a 4-bit counter holds.
        for (int i = 0; i < 6; i++)
            step(mkv("sat_lu", 1, 9, 9, 0, 1, 0, 0, 0, 0, LU), 1'b0);
        for (int i = 0; i < 16; i++)
            step(mkv("sat_br", 0, 0, 0, 0, 0, 0, 1, 0, 0, BR), 1'b0);
        check("stall_cnt saturated", 32'(stall_cnt), 32'hF);
        check("flush_cnt saturated", 32'(flush_cnt), 32'hF);

        // Reset asserted on cycle 2 of an MDU stall, inputs still busy.
        step(mkv("rst_c0", 0, 0, 0, 0, 0, 0, 0, 1, 0, MDU), 1'b0);
        step(mkv("rst_c1", 0, 0, 0, 0, 0, 0, 0, 1, 0, MDU), 1'b0);
        #2;
        check("rst_c2 pre ctrl", 32'(outs()), 32'(MDU));
        reset = 1'b1;
        #1;
        check("rst_mid ctrl",      32'(outs()), 32'(ADV));
        check("rst_mid stall_cnt", 32'(stall_cnt), 0);
        check("rst_mid flush_cnt", 32'(flush_cnt), 0);
        check("rst_mid timeout",   32'(mdu_timeout), 0);
        @(posedge clk); #1;
        reset = 1'b0;
        exp_stall = 0; exp_flush = 0; exp_to = 1'b0;
        step(idle, 1'b0);
        step(mkv("post_rst_lu", 1, 3, 0, 3, 0, 1, 0, 0, 0, LU), 1'b0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
